// File: rtl/pc_stack_unit_if.sv
// pc_stack_unit_if: control-unit strobes into the PC/return-stack stage and its registered state back out.
interface pc_stack_unit_if #(
    parameter int PC_WIDTH    = 10,
    parameter int STACK_DEPTH = 8
);
    logic                             write_pc;
    logic [2:0]                       branch;
    logic                             push;
    logic                             pop;
    logic                             add_pc;
    logic                             brfl_control;
    logic                             flag_true;
    logic [PC_WIDTH-1:0]              reg_target;
    logic [PC_WIDTH-1:0]              imm_target;
    logic [PC_WIDTH-1:0]              offset;
    logic [PC_WIDTH-1:0]              pc;
    logic                             halted;
    logic                             stack_overflow;
    logic                             stack_underflow;
    logic [$clog2(STACK_DEPTH):0]     sp;

    modport master (
        output write_pc, branch, push, pop, add_pc, brfl_control, flag_true,
               reg_target, imm_target, offset,
        input  pc, halted, stack_overflow, stack_underflow, sp
    );

    modport slave (
        input  write_pc, branch, push, pop, add_pc, brfl_control, flag_true,
               reg_target, imm_target, offset,
        output pc, halted, stack_overflow, stack_underflow, sp
    );
endinterface

// File: rtl/pc_stack_unit.sv
// pc_stack_unit: next-PC selection for sequential/jr/jpc/brfl/call/ret/halt flow with a return-address LIFO.
module pc_stack_unit #(
    parameter int PC_WIDTH    = 10,
    parameter int STACK_DEPTH = 8,
    parameter int RESET_PC    = 0
) (
    input logic            clk,
    input logic            rst,
    pc_stack_unit_if.slave bus
);
    localparam int AW = $clog2(STACK_DEPTH);

    logic [PC_WIDTH-1:0] stack [STACK_DEPTH];
    logic [PC_WIDTH-1:0] pc_q, seq_pc, flow_pc, top, pop_pc;
    logic [AW:0]         sp_q, sp_m1;
    logic [AW-1:0]       waddr;
    logic                halted_q, ovf_q, unf_q, commit, is_halt, empty, full, we;

    assign sp_m1   = sp_q - 1'b1;
    assign top     = stack[sp_m1[AW-1:0]];
    assign empty   = sp_q == '0;
    assign full    = sp_q == (AW+1)'(STACK_DEPTH);
    assign commit  = bus.write_pc && !halted_q;
    assign is_halt = bus.branch == 3'b011;
    assign seq_pc  = pc_q + 1'b1;
    assign pop_pc  = top + {{(PC_WIDTH-1){1'b0}}, bus.add_pc};

    always_comb begin
        flow_pc = bus.branch == 3'b001 ? bus.reg_target :
                  bus.branch == 3'b100 ? seq_pc + bus.offset :
                  bus.branch == 3'b010 ? bus.imm_target :
                  (bus.brfl_control && bus.flag_true) ? bus.imm_target : seq_pc;
    end

    // A swap overwrites the current top; a plain push appends at sp.
    assign we    = commit && !is_halt && bus.push && (bus.pop ? !empty : !full);
    assign waddr = bus.pop ? sp_m1[AW-1:0] : sp_q[AW-1:0];

    always_ff @(posedge clk) begin
        if (we) stack[waddr] <= pc_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= PC_WIDTH'(RESET_PC);
            sp_q     <= '0;
            halted_q <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else if (commit) begin
            if (is_halt) begin
                halted_q <= 1'b1;
            end else if (bus.pop) begin
                if (empty) begin
                    unf_q    <= 1'b1;
                    halted_q <= 1'b1;
                end else begin
                    pc_q <= pop_pc;
                    if (!bus.push) sp_q <= sp_m1;
                end
            end else if (bus.push) begin
                if (full) begin
                    ovf_q    <= 1'b1;
                    halted_q <= 1'b1;
                end else begin
                    pc_q <= bus.branch == 3'b010 ? bus.imm_target : seq_pc;
                    sp_q <= sp_q + 1'b1;
                end
            end else begin
                pc_q <= flow_pc;
            end
        end
    end

    assign bus.pc              = pc_q;
    assign bus.sp              = sp_q;
    assign bus.halted          = halted_q;
    assign bus.stack_overflow  = ovf_q;
    assign bus.stack_underflow = unf_q;
endmodule

// File: doc/pc_stack_unit.md
# pc_stack_unit

Program-counter and return-address-stack stage that sits directly downstream of the microprogrammed control unit in the multicycle core. It consumes the control unit's `write_pc`, `branch`, `push`, `pop`, `add_pc` and `brfl_control` strobes. It computes the next PC for sequential, jump-register, PC-relative, conditional, call, return and halt flow, and holds return addresses in a small hardware LIFO. Its `pc` output addresses instruction memory for the next fetch.

## Interface
- `PC_WIDTH`, 10, PC and all target widths, in instruction-word units.
- `STACK_DEPTH`, 8, return-stack entries; power of two, ≥2.
- `RESET_PC`, 0, PC value after reset.
- `clk`  in  1  core clock; all state changes on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `write_pc`  in  1  commit strobe; one-cycle pulse at the end of each instruction.
- `branch`  in  3  flow select: 000 sequential, 001 jr, 010 call, 011 halt, 100 jpc; 101–111 are treated as 000.
- `push`  in  1  push the current PC onto the stack (asserted with call).
- `pop`  in  1  pop top-of-stack into the PC (return).
- `add_pc`  in  1  with `pop`: new PC = popped + 1; otherwise new PC = popped.
- `brfl_control`  in  1  conditional branch on flag.
- `flag_true`  in  1  ALU flag result for brfl.
- `reg_target`  in  PC_WIDTH  register-file operand for jr.
- `imm_target`  in  PC_WIDTH  absolute target for call and taken brfl.
- `offset`  in  PC_WIDTH  two's-complement displacement for jpc.
- `pc`  out  PC_WIDTH  current PC.
- `halted`  out  1  sticky halt.
- `stack_overflow`  out  1  sticky: push attempted on a full stack.
- `stack_underflow`  out  1  sticky: pop attempted on an empty stack.
- `sp`  out  log2(STACK_DEPTH)+1  number of valid stack entries.

## Operation
- Reset, synchronous on `rst`: `pc`=RESET_PC; `halted`, `stack_overflow`, `stack_underflow`=0; `sp`=0. Stack RAM contents are don't-care.
- State changes only on an edge where `write_pc`=1 and `halted`=0. All other inputs are ignored otherwise, and all state holds.
- Priority when committing, highest first:
  1. `branch`=011: `halted`←1; `pc` holds.
  2. `pop` and `push` both 1 (swap):
     - if `sp`=0: underflow error (see below);
     - otherwise: top entry ← `pc`; `pc` ← old top (+1 if `add_pc`); `sp` unchanged.
  3. `pop`:
     - if `sp`=0: `stack_underflow`←1, `halted`←1, `pc` holds;
     - otherwise: `pc` ← top (+1 if `add_pc`); `sp`−1.
  4. `push`:
     - if `sp`=STACK_DEPTH: `stack_overflow`←1, `halted`←1, `pc` holds;
     - otherwise: stack[`sp`] ← `pc`; `sp`+1; `pc` ← `imm_target` if `branch`=010, else `pc`+1.
  5. `branch`=001: `pc` ← `reg_target`.
  6. `branch`=100: `pc` ← `pc` + 1 + `offset`.
  7. `brfl_control`=1 and `flag_true`=1: `pc` ← `imm_target`.
  8. Otherwise (including brfl not taken): `pc` ← `pc`+1.
- Arithmetic is modulo 2^PC_WIDTH. `pc`+1 wraps from all-ones to 0. The jpc sum wraps and carries are discarded; `offset` is interpreted as signed.
- `branch`=010 without `push` jumps to `imm_target` with no push.
- Only `rst` clears `halted` and the error flags.

## Timing
- `pc`, `sp` and the flags are registered. A commit sampled at edge N is visible after edge N. Zero combinational paths from inputs to outputs.
- Stack read of the top entry is combinational from `sp`−1, so a return completes in the same commit edge.
- A push followed by a pop on the next commit returns the pushed value; there is no write-to-read hazard.
- Back-to-back `write_pc` on consecutive cycles is legal; each pulse is one commit.
- `rst` asserted concurrently with `write_pc` wins; the commit is discarded.

## Test plan
All scenarios use PC_WIDTH=10, STACK_DEPTH=4.
- Reset then 3 sequential commits (`branch`=000) → `pc`=0,1,2,3; `sp`=0; flags 0.
- At `pc`=5: call (`push`=1, `branch`=010, `imm_target`=0x100), then ret (`pop`=1, `add_pc`=1) → `pc`=0x100, `sp`=1, then `pc`=6, `sp`=0.
- Four nested calls, then a fifth call → `sp`=4 with `stack_overflow`=1, `halted`=1 and `pc` frozen. Further `write_pc` pulses cause no change; `rst` recovers to `pc`=0.
- Ret at `sp`=0 → `stack_underflow`=1, `halted`=1, `pc` unchanged.
- jpc at `pc`=0x3FE with `offset`=0x001 → `pc`=0x000 (wrap). jpc at `pc`=10 with `offset`=0x3FD (−3) → `pc`=8. jr with `reg_target`=0x2A → `pc`=0x2A.
- brfl with `imm_target`=0x40: `flag_true`=0 at `pc`=7 → `pc`=8; `flag_true`=1 → `pc`=0x40. halt, then `write_pc` pulses → `pc` holds, `halted`=1.
